// File: rtl/multi_port_hazard_unit.sv
// multi_port_hazard_unit
// Operand forwarding and load-use stall unit for the decode stage. Every source
// port is resolved in one combinational pass against NUM_STAGES producer slots
// (slot 0 = youngest). While the instruction is stalled, a port that has
// resolved is captured so that a producer retiring mid-stall cannot expose
// stale register-file data to decode.
//
// Optional feature: define HAZARD_STALL_COUNTER_EN to build the saturating
// stall-cycle counter; otherwise stall_cycles is tied to zero.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   issue_valid         decode holds a valid instruction
//   issue_advance       instruction leaves decode at this posedge
//   skip_stages         number of youngest slots to ignore (bubbles)
//   src_id/src_rf_data  per-port source id and register-file data (packed)
//   fwd_id/fwd_ready/fwd_data  per-slot producer id (0 = no write), valid, data
//   operand_data        final per-port operand values
//   port_stall, stall   per-port pending flags and their OR
//   stall_cycles        stall performance counter
//   port_state_dbg      per-port FSM state, 2 bits per port
//
// Handshake: decode presents an instruction with issue_valid=1 and holds it
// until the posedge where issue_advance=1. issue_advance may only be raised
// while stall=0; dropping issue_valid or advancing returns every port to IDLE.
module multi_port_hazard_unit #(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_STAGES = 3,
  parameter int DATA_W     = 32,
  parameter int REG_ID_W   = 5,
  localparam int SKIP_W    = $clog2(NUM_STAGES + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic                          issue_advance,
  input  logic [SKIP_W-1:0]             skip_stages,
  input  logic [NUM_PORTS*REG_ID_W-1:0] src_id,
  input  logic [NUM_PORTS*DATA_W-1:0]   src_rf_data,
  input  logic [NUM_STAGES*REG_ID_W-1:0] fwd_id,
  input  logic [NUM_STAGES-1:0]         fwd_ready,
  input  logic [NUM_STAGES*DATA_W-1:0]  fwd_data,
  output logic [NUM_PORTS*DATA_W-1:0]   operand_data,
  output logic [NUM_PORTS-1:0]          port_stall,
  output logic                          stall,
  output logic [15:0]                   stall_cycles,
  output logic [NUM_PORTS*2-1:0]        port_state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  logic [NUM_PORTS*DATA_W-1:0] res_data;
  logic [NUM_PORTS-1:0]        pend;

  logic [1:0]        state_q [NUM_PORTS];
  logic [1:0]        state_d [NUM_PORTS];
  logic [DATA_W-1:0] held_q  [NUM_PORTS];
  logic [DATA_W-1:0] held_d  [NUM_PORTS];

  // Resolution. Slots are walked oldest to youngest so the youngest matching
  // slot (lowest index not skipped) is written last and wins. A pending port
  // reports register-file data; consumers must ignore it while stalled.
  always_comb begin
    res_data = src_rf_data;
    pend     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (src_id[p*REG_ID_W +: REG_ID_W] != '0) begin
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
          if (i >= int'(skip_stages) &&
              fwd_id[i*REG_ID_W +: REG_ID_W] == src_id[p*REG_ID_W +: REG_ID_W]) begin
            if (fwd_ready[i]) begin
              res_data[p*DATA_W +: DATA_W] = fwd_data[i*DATA_W +: DATA_W];
              pend[p] = 1'b0;
            end else begin
              res_data[p*DATA_W +: DATA_W] = src_rf_data[p*DATA_W +: DATA_W];
              pend[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Outputs. A HELD port is never pending: its value was frozen at capture.
  always_comb begin
    operand_data   = res_data;
    port_stall     = '0;
    port_state_dbg = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (state_q[p] == ST_HELD) begin
        operand_data[p*DATA_W +: DATA_W] = held_q[p];
      end
      port_stall[p] = issue_valid && (state_q[p] != ST_HELD) && pend[p];
      port_state_dbg[p*2 +: 2] = state_q[p];
    end
  end

  assign stall = |port_stall;

  // Per-port FSM. Clearing on advance/invalid takes priority over capture.
  // A port that resolves in the cycle stall drops is not captured: the
  // consumer takes the combinational value at that edge.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      held_d[p]  = held_q[p];
      if (!issue_valid || issue_advance) begin
        state_d[p] = ST_IDLE;
      end else if (stall && !pend[p] && state_q[p] != ST_HELD) begin
        state_d[p] = ST_HELD;
        held_d[p]  = res_data[p*DATA_W +: DATA_W];
      end else if (pend[p] && state_q[p] == ST_IDLE) begin
        state_d[p] = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= ST_IDLE;
        held_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= state_d[p];
        held_q[p]  <= held_d[p];
      end
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Saturates rather than wraps so a long stall never reads as a short one.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule
